pipe_ctrl: RTL and testbench

Pipelined control and hazard unit for the five-stage WISC processor: it replaces the single-cycle opcode decoder. It decodes the 4-bit opcode in ID and carries the control bits through the ID/EX, EX/MEM and MEM/WB registers. It also detects RAW hazards, generates EX-stage forwarding selects, flushes on taken branches and tracks HLT to a sticky halted flag. It sits beside the datapath pipeline registers, which hold data only; all control state lives here.

---
 rtl/pipe_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipelined control and hazard unit for the five-stage WISC core: decodes in ID, carries
// control through ID/EX, EX/MEM and MEM/WB, and handles stalls, forwarding, flushes and HLT.
module pipe_ctrl #(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              ex_br_taken,
    output logic              stall,
    output logic              flush,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_alusrc,
    output logic              ex_branch,
    output logic              ex_halt,
    output logic [3:0]        ex_opcode,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_regwrite,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_memtoreg,
    output logic              mem_halt,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic              wb_halt,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned FWD_W = 2;

    localparam logic [OP_W-1:0] OP_LW  = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(4'b1001);
    localparam logic [OP_W-1:0] OP_PCS = OP_W'(4'b1110);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111);

    localparam logic [FWD_W-1:0] FWD_RF  = FWD_W'(2'b00);
    localparam logic [FWD_W-1:0] FWD_WB  = FWD_W'(2'b01);
    localparam logic [FWD_W-1:0] FWD_MEM = FWD_W'(2'b10);

    typedef struct packed {
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic              alusrc;
        logic              branch;
        logic              halt;
        logic [OP_W-1:0]   opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              rs_used;
        logic              rt_used;
    } idex_t;

    typedef struct packed {
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic              halt;
        logic [REG_AW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              halt;
        logic [REG_AW-1:0] rd;
    } memwb_t;

    idex_t  dec;
    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;
    logic   halt_pend_d, halt_pend_q;
    logic   halted_d, halted_q;
    logic   load_use, raw_ex, raw_mem, hazard;
    logic   stall_c, bubble;
    logic [FWD_W-1:0] fwd_a_c, fwd_b_c;

    // Register 0 is hardwired to zero, so it never matches as a producer.
    function automatic logic src_hit(input logic used, input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
        return used && (dst != '0) && (src == dst);
    endfunction

    function automatic logic [FWD_W-1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] src,
                                                 input exmem_t m, input memwb_t w);
        if (m.regwrite && src_hit(used, src, m.rd)) begin
            return FWD_MEM;
        end
        if (w.regwrite && src_hit(used, src, w.rd)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    // ID-stage opcode decode.
    always_comb begin
        dec          = '0;
        dec.opcode   = id_opcode;
        dec.rd       = id_rd;
        dec.rs       = id_rs;
        dec.rt       = id_rt;
        dec.rs_used  = id_rs_used;
        dec.rt_used  = id_rt_used;
        dec.memread  = (id_opcode == OP_LW);
        dec.memtoreg = (id_opcode == OP_LW);
        dec.memwrite = (id_opcode == OP_SW);
        dec.halt     = (id_opcode == OP_HLT);
        dec.branch   = (id_opcode[3:1] == 3'b110);
        dec.regwrite = !id_opcode[3] || (id_opcode == OP_LW) || (id_opcode[3:1] == 3'b101)
                       || (id_opcode == OP_PCS);
        dec.alusrc   = ((id_opcode >= OP_W'(4'b0100)) && (id_opcode <= OP_W'(4'b0110)))
                       || (id_opcode[3:2] == 2'b10);
    end

    // Hazard detection, bubble insertion and pipeline advance.
    always_comb begin
        load_use = idex_q.memread && (src_hit(id_rs_used, id_rs, idex_q.rd)
                                      || src_hit(id_rt_used, id_rt, idex_q.rd));
        raw_ex   = idex_q.regwrite && (src_hit(id_rs_used, id_rs, idex_q.rd)
                                       || src_hit(id_rt_used, id_rt, idex_q.rd));
        raw_mem  = exmem_q.regwrite && (src_hit(id_rs_used, id_rs, exmem_q.rd)
                                        || src_hit(id_rt_used, id_rt, exmem_q.rd));
        hazard   = load_use || ((FWD_EN == 0) && (raw_ex || raw_mem));
        stall_c  = id_valid && hazard && !ex_br_taken;
        bubble   = !id_valid || stall_c || ex_br_taken || halt_pend_q;

        idex_d   = bubble ? idex_t'('0) : dec;

        exmem_d          = '0;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.memtoreg = idex_q.memtoreg;
        exmem_d.halt     = idex_q.halt;
        exmem_d.rd       = idex_q.rd;

        memwb_d          = '0;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.halt     = exmem_q.halt;
        memwb_d.rd       = exmem_q.rd;

        halt_pend_d = halt_pend_q || idex_d.halt;
        halted_d    = halted_q || memwb_q.halt;
    end

    // EX-stage operand forwarding; tied to the register file when no bypass network exists.
    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        if (FWD_EN != 0) begin
            fwd_a_c = fwd_sel(idex_q.rs_used, idex_q.rs, exmem_q, memwb_q);
            fwd_b_c = fwd_sel(idex_q.rt_used, idex_q.rt, exmem_q, memwb_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            halt_pend_q <= halt_pend_d;
            halted_q    <= halted_d;
        end
    end

    assign stall        = stall_c;
    assign flush        = ex_br_taken;
    assign ex_regwrite  = idex_q.regwrite;
    assign ex_memread   = idex_q.memread;
    assign ex_memwrite  = idex_q.memwrite;
    assign ex_memtoreg  = idex_q.memtoreg;
    assign ex_alusrc    = idex_q.alusrc;
    assign ex_branch    = idex_q.branch;
    assign ex_halt      = idex_q.halt;
    assign ex_opcode    = idex_q.opcode;
    assign ex_rd        = idex_q.rd;
    assign mem_regwrite = exmem_q.regwrite;
    assign mem_memread  = exmem_q.memread;
    assign mem_memwrite = exmem_q.memwrite;
    assign mem_memtoreg = exmem_q.memtoreg;
    assign mem_halt     = exmem_q.halt;
    assign mem_rd       = exmem_q.rd;
    assign wb_regwrite  = memwb_q.regwrite;
    assign wb_memtoreg  = memwb_q.memtoreg;
    assign wb_halt      = memwb_q.halt;
    assign wb_rd        = memwb_q.rd;
    assign fwd_a        = fwd_a_c;
    assign fwd_b        = fwd_b_c;
    assign halted       = halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one forwarding and one non-forwarding instance share stimulus.
module tb_pipe_ctrl;

    localparam int unsigned REG_AW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [3:0]        id_opcode;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_rs_used, id_rt_used;
    logic              ex_br_taken;

    logic f_stall, f_flush, f_ex_regwrite, f_ex_memread, f_ex_memwrite, f_ex_memtoreg;
    logic f_ex_alusrc, f_ex_branch, f_ex_halt, f_mem_regwrite, f_mem_memread, f_mem_memwrite;
    logic f_mem_memtoreg, f_mem_halt, f_wb_regwrite, f_wb_memtoreg, f_wb_halt, f_halted;
    logic [3:0] f_ex_opcode;
    logic [REG_AW-1:0] f_ex_rd, f_mem_rd, f_wb_rd;
    logic [1:0] f_fwd_a, f_fwd_b;

    logic n_stall, n_flush, n_ex_regwrite, n_ex_memread, n_ex_memwrite, n_ex_memtoreg;
    logic n_ex_alusrc, n_ex_branch, n_ex_halt, n_mem_regwrite, n_mem_memread, n_mem_memwrite;
    logic n_mem_memtoreg, n_mem_halt, n_wb_regwrite, n_wb_memtoreg, n_wb_halt, n_halted;
    logic [3:0] n_ex_opcode;
    logic [REG_AW-1:0] n_ex_rd, n_mem_rd, n_wb_rd;
    logic [1:0] n_fwd_a, n_fwd_b;

    logic [35:0] f_all, n_all;
    logic [14:0] f_ex_all, n_ex_all;
    logic [6:0]  f_ex_ctrl;
    logic [6:0]  dec_exp [16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_AW(REG_AW), .FWD_EN(1)) u_fwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_br_taken(ex_br_taken),
        .stall(f_stall), .flush(f_flush),
        .ex_regwrite(f_ex_regwrite), .ex_memread(f_ex_memread), .ex_memwrite(f_ex_memwrite),
        .ex_memtoreg(f_ex_memtoreg), .ex_alusrc(f_ex_alusrc), .ex_branch(f_ex_branch),
        .ex_halt(f_ex_halt), .ex_opcode(f_ex_opcode), .ex_rd(f_ex_rd),
        .mem_regwrite(f_mem_regwrite), .mem_memread(f_mem_memread),
        .mem_memwrite(f_mem_memwrite), .mem_memtoreg(f_mem_memtoreg),
        .mem_halt(f_mem_halt), .mem_rd(f_mem_rd),
        .wb_regwrite(f_wb_regwrite), .wb_memtoreg(f_wb_memtoreg), .wb_halt(f_wb_halt),
        .wb_rd(f_wb_rd), .fwd_a(f_fwd_a), .fwd_b(f_fwd_b), .halted(f_halted)
    );

    pipe_ctrl #(.REG_AW(REG_AW), .FWD_EN(0)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_br_taken(ex_br_taken),
        .stall(n_stall), .flush(n_flush),
        .ex_regwrite(n_ex_regwrite), .ex_memread(n_ex_memread), .ex_memwrite(n_ex_memwrite),
        .ex_memtoreg(n_ex_memtoreg), .ex_alusrc(n_ex_alusrc), .ex_branch(n_ex_branch),
        .ex_halt(n_ex_halt), .ex_opcode(n_ex_opcode), .ex_rd(n_ex_rd),
        .mem_regwrite(n_mem_regwrite), .mem_memread(n_mem_memread),
        .mem_memwrite(n_mem_memwrite), .mem_memtoreg(n_mem_memtoreg),
        .mem_halt(n_mem_halt), .mem_rd(n_mem_rd),
        .wb_regwrite(n_wb_regwrite), .wb_memtoreg(n_wb_memtoreg), .wb_halt(n_wb_halt),
        .wb_rd(n_wb_rd), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b), .halted(n_halted)
    );

    assign f_ex_ctrl = {f_ex_regwrite, f_ex_memread, f_ex_memwrite, f_ex_memtoreg,
                        f_ex_alusrc, f_ex_branch, f_ex_halt};
    assign f_ex_all  = {f_ex_ctrl, f_ex_opcode, f_ex_rd};
    assign n_ex_all  = {n_ex_regwrite, n_ex_memread, n_ex_memwrite, n_ex_memtoreg,
                        n_ex_alusrc, n_ex_branch, n_ex_halt, n_ex_opcode, n_ex_rd};
    assign f_all = {f_ex_all, f_mem_regwrite, f_mem_memread, f_mem_memwrite, f_mem_memtoreg,
                    f_mem_halt, f_mem_rd, f_wb_regwrite, f_wb_memtoreg, f_wb_halt, f_wb_rd,
                    f_fwd_a, f_fwd_b, f_halted};
    assign n_all = {n_ex_all, n_mem_regwrite, n_mem_memread, n_mem_memwrite, n_mem_memtoreg,
                    n_mem_halt, n_mem_rd, n_wb_regwrite, n_wb_memtoreg, n_wb_halt, n_wb_rd,
                    n_fwd_a, n_fwd_b, n_halted};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic [REG_AW-1:0] rs,
                          input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                          input logic rsu, input logic rtu);
        id_valid   = v;
        id_opcode  = op;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_rs_used = rsu;
        id_rt_used = rtu;
    endtask

    task automatic drain();
        set_id(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) cyc();
    endtask

    initial begin
        // {regwrite, memread, memwrite, memtoreg, alusrc, branch, halt}
        dec_exp = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                    7'b1000100, 7'b1000100, 7'b1000100, 7'b1000000,
                    7'b1101100, 7'b0010100, 7'b1000100, 7'b1000100,
                    7'b0000010, 7'b0000010, 7'b1000000, 7'b0000001};

        rst_n       = 1'b0;
        ex_br_taken = 1'b0;
        set_id(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) cyc();
        chk("reset_f_state", 64'(f_all), 64'd0);
        chk("reset_n_state", 64'(n_all), 64'd0);
        chk("reset_stall_flush", 64'({f_stall, f_flush, n_stall, n_flush}), 64'd0);
        rst_n = 1'b1;
        drain();

        // Load-use with forwarding: one stall cycle, then WB forward.
        set_id(1'b1, 4'h8, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0);
        #1 chk("lu_lw_nostall", 64'(f_stall), 64'd0);
        cyc();
        set_id(1'b1, 4'h0, 4'd3, 4'd5, 4'd4, 1'b1, 1'b1);
        #1 chk("lu_stall_on", 64'(f_stall), 64'd1);
        cyc();
        chk("lu_bubble", 64'(f_ex_all), 64'd0);
        #1 chk("lu_stall_off", 64'(f_stall), 64'd0);
        cyc();
        chk("lu_ex_rd", 64'({f_ex_regwrite, f_ex_rd}), 64'({1'b1, 4'd4}));
        chk("lu_fwd", 64'({f_fwd_a, f_fwd_b}), 64'({2'b01, 2'b00}));
        drain();

        // ALU RAW: forward from MEM with bypass, two-cycle stall without.
        set_id(1'b1, 4'h0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1);
        #1 chk("raw_add_nostall", 64'({f_stall, n_stall}), 64'd0);
        cyc();
        set_id(1'b1, 4'h1, 4'd3, 4'd3, 4'd6, 1'b1, 1'b1);
        #1 chk("raw_f_nostall", 64'(f_stall), 64'd0);
        chk("raw_n_stall1", 64'(n_stall), 64'd1);
        cyc();
        chk("raw_f_fwd", 64'({f_fwd_a, f_fwd_b}), 64'({2'b10, 2'b10}));
        chk("raw_n_bubble", 64'(n_ex_all), 64'd0);
        #1 chk("raw_n_stall2", 64'(n_stall), 64'd1);
        cyc();
        #1 chk("raw_n_release", 64'(n_stall), 64'd0);
        cyc();
        chk("raw_n_ex", 64'({n_ex_opcode, n_ex_rd, n_fwd_a, n_fwd_b}),
            64'({4'h1, 4'd6, 2'b00, 2'b00}));
        drain();

        // Register 0 never creates a hazard or a forward.
        set_id(1'b1, 4'h8, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0);
        cyc();
        set_id(1'b1, 4'h0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1);
        #1 chk("r0_nostall", 64'({f_stall, n_stall}), 64'd0);
        cyc();
        chk("r0_fwd", 64'({f_fwd_a, f_fwd_b}), 64'd0);
        drain();

        // Taken branch in EX with a dependent instruction in ID.
        set_id(1'b1, 4'h8, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0);
        cyc();
        set_id(1'b1, 4'hC, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 4'h0, 4'd3, 4'd4, 4'd5, 1'b1, 1'b1);
        ex_br_taken = 1'b1;
        #1 chk("br_flush_prio", 64'({f_flush, f_stall, n_flush, n_stall}), 64'b1010);
        cyc();
        ex_br_taken = 1'b0;
        chk("br_f_bubble", 64'(f_ex_all), 64'd0);
        chk("br_n_bubble", 64'(n_ex_all), 64'd0);
        drain();

        // Flush beats a load-use hazard on the forwarding unit.
        set_id(1'b1, 4'h8, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0);
        cyc();
        set_id(1'b1, 4'h0, 4'd3, 4'd4, 4'd5, 1'b1, 1'b1);
        ex_br_taken = 1'b1;
        #1 chk("br_lu_prio", 64'({f_flush, f_stall}), 64'b10);
        cyc();
        ex_br_taken = 1'b0;
        chk("br_lu_bubble", 64'(f_ex_all), 64'd0);
        drain();

        // Decode table, plus propagation of LW through MEM and WB.
        for (int i = 0; i < 15; i++) begin
            set_id(1'b1, 4'(i), 4'd0, 4'd0, 4'(i), 1'b0, 1'b0);
            cyc();
            chk($sformatf("dec_op%0d", i), 64'({f_ex_ctrl, f_ex_opcode}),
                64'({dec_exp[i], 4'(i)}));
            if (i == 9) begin
                chk("dec_mem_lw", 64'({f_mem_regwrite, f_mem_memread, f_mem_memtoreg, f_mem_rd}),
                    64'({3'b111, 4'd8}));
            end
            if (i == 10) begin
                chk("dec_wb_lw", 64'({f_wb_regwrite, f_wb_memtoreg, f_wb_rd}),
                    64'({2'b11, 4'd8}));
                chk("dec_mem_sw", 64'({f_mem_regwrite, f_mem_memwrite}), 64'b01);
            end
        end
        drain();

        // HLT killed by a taken branch never becomes pending.
        set_id(1'b1, 4'hF, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        ex_br_taken = 1'b1;
        cyc();
        ex_br_taken = 1'b0;
        chk("hlt_kill_ex", 64'({f_ex_halt, n_ex_halt}), 64'd0);
        drain();
        set_id(1'b1, 4'h0, 4'd1, 4'd2, 4'd9, 1'b1, 1'b1);
        cyc();
        chk("hlt_kill_not_pending", 64'({f_ex_regwrite, f_ex_rd, f_halted}), 64'({1'b1, 4'd9, 1'b0}));
        drain();

        // ADD, HLT, ADD: HLT retires, younger ADD is bubbled, halted is sticky.
        set_id(1'b1, 4'h0, 4'd2, 4'd2, 4'd1, 1'b1, 1'b1);
        cyc();
        set_id(1'b1, 4'hF, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc();
        chk("hlt_ex", 64'({f_ex_halt, n_ex_halt}), 64'b11);
        set_id(1'b1, 4'h0, 4'd2, 4'd2, 4'd7, 1'b1, 1'b1);
        cyc();
        chk("hlt_mem", 64'({f_mem_halt, f_ex_regwrite}), 64'b10);
        cyc();
        chk("hlt_wb", 64'({f_wb_halt, f_halted, n_wb_halt, n_halted}), 64'b1010);
        cyc();
        chk("hlt_halted", 64'({f_halted, n_halted}), 64'b11);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("hlt_sticky%0d", i), 64'({f_halted, n_halted, f_ex_regwrite, n_ex_regwrite}),
                64'b1100);
        end

        // Asynchronous reset between edges clears halted and pending.
        #2 rst_n = 1'b0;
        #1 chk("rst_halted", 64'({f_halted, n_halted}), 64'd0);
        #2 rst_n = 1'b1;
        set_id(1'b1, 4'h0, 4'd2, 4'd2, 4'd1, 1'b1, 1'b1);
        cyc();
        set_id(1'b1, 4'h0, 4'd3, 4'd4, 4'd2, 1'b1, 1'b1);
        cyc();
        chk("rst_refill", 64'({f_ex_regwrite, f_ex_rd, f_mem_regwrite, f_mem_rd}),
            64'({1'b1, 4'd2, 1'b1, 4'd1}));
        #2 rst_n = 1'b0;
        #1 chk("rst_async_f", 64'(f_all), 64'd0);
        chk("rst_async_n", 64'(n_all), 64'd0);
        #2 rst_n = 1'b1;
        set_id(1'b1, 4'h9, 4'd1, 4'd2, 4'd0, 1'b1, 1'b1);
        cyc();
        chk("rst_sw_f", 64'({f_ex_memwrite, f_ex_alusrc, f_ex_regwrite, f_ex_opcode}),
            64'({3'b110, 4'h9}));
        chk("rst_sw_n", 64'({n_ex_memwrite, n_ex_alusrc, n_ex_regwrite}), 64'b110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
